// File: rtl/window_stream_scheduler.sv
// Overlapped-window (50%) sample FIFO sequencer: gates input on buffered depth, issues window
// read bursts once a full window is buffered, and re-emits RAM read data as a tagged stream
// through a 2-entry skid buffer paced by downstream backpressure.
module window_stream_scheduler #(
  parameter int unsigned ADDRWIDTH = 12,
  parameter int unsigned DATAWIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATAWIDTH-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 enqueue,
  output logic [DATAWIDTH-1:0] wr_data,
  output logic                 dequeue,
  input  logic [DATAWIDTH-1:0] rd_data,
  output logic [DATAWIDTH-1:0] m_data,
  output logic [ADDRWIDTH-1:0] m_index,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy
);

  localparam logic [ADDRWIDTH:0]   WinLen  = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH:0]   HalfLen = WinLen >> 1;
  localparam logic [ADDRWIDTH-1:0] LastIdx = {ADDRWIDTH{1'b1}};

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e               state_q, state_d;
  logic [ADDRWIDTH:0]   ahead_q, ahead_d;
  logic [ADDRWIDTH-1:0] rd_cnt_q, rd_cnt_d;

  // One read in flight: RAM data returns the cycle after dequeue.
  logic                 infl_q, infl_d;
  logic [ADDRWIDTH-1:0] infl_idx_q, infl_idx_d;
  logic                 infl_last_q, infl_last_d;

  // Two-entry output buffer, circular with a 1-bit head pointer.
  logic [DATAWIDTH-1:0] buf_data_q [2];
  logic [ADDRWIDTH-1:0] buf_idx_q  [2];
  logic                 buf_last_q [2];
  logic                 head_q, head_d;
  logic [1:0]           count_q, count_d;

  logic       pop;
  logic       push;
  logic       tail;
  logic       win_end;
  logic [1:0] occ_after_pop;

  // Input side, output side and dequeue pacing.
  always_comb begin
    s_ready       = (ahead_q < WinLen);
    enqueue       = s_valid && s_ready;
    wr_data       = s_data;
    busy          = (state_q == StBurst);
    m_valid       = (count_q != 2'd0);
    pop           = m_valid && m_ready;
    push          = infl_q;
    tail          = head_q ^ count_q[0];
    occ_after_pop = count_q - {1'b0, pop};
    // Buffer slots after this cycle's pop plus the read still in flight must leave room.
    dequeue       = busy && (({1'b0, occ_after_pop} + {2'b00, infl_q}) < 3'd2);
    win_end       = dequeue && (rd_cnt_q == LastIdx);
    m_data        = m_valid ? buf_data_q[head_q] : '0;
    m_index       = m_valid ? buf_idx_q[head_q]  : '0;
    m_last        = m_valid ? buf_last_q[head_q] : 1'b0;
  end

  // Next-state: burst FSM, ahead accounting, read counter, in-flight tag, buffer pointers.
  always_comb begin
    state_d     = state_q;
    ahead_d     = ahead_q + {{ADDRWIDTH{1'b0}}, enqueue} - (win_end ? HalfLen : '0);
    rd_cnt_d    = rd_cnt_q;
    infl_d      = dequeue;
    infl_idx_d  = rd_cnt_q;
    infl_last_d = (rd_cnt_q == LastIdx);
    head_d      = pop ? ~head_q : head_q;
    count_d     = count_q - {1'b0, pop} + {1'b0, push};

    if (dequeue) begin
      rd_cnt_d = win_end ? '0 : rd_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle:  if (ahead_q == WinLen) state_d = StBurst;
      StBurst: if (win_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; reset drops in-flight reads too.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ahead_q     <= '0;
      rd_cnt_q    <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      head_q      <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_idx_q[i]  <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      ahead_q     <= ahead_d;
      rd_cnt_q    <= rd_cnt_d;
      infl_q      <= infl_d;
      infl_idx_q  <= infl_idx_d;
      infl_last_q <= infl_last_d;
      head_q      <= head_d;
      count_q     <= count_d;
      if (push) begin
        buf_data_q[tail] <= rd_data;
        buf_idx_q[tail]  <= infl_idx_q;
        buf_last_q[tail] <= infl_last_q;
      end
    end
  end

endmodule

// File: tb/tb_window_stream_scheduler.sv
// Bench for window_stream_scheduler with N=8: a history-based FIFO/RAM model supplies rd_data,
// and a scoreboard checks every output against the overlapped-window formula.
module tb_window_stream_scheduler;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int N  = 8;
  localparam int H  = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          enqueue;
  logic [DW-1:0] wr_data;
  logic          dequeue;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_index;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;

  window_stream_scheduler #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .enqueue (enqueue),
    .wr_data (wr_data),
    .dequeue (dequeue),
    .rd_data (rd_data),
    .m_data  (m_data),
    .m_index (m_index),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: every accepted sample in order; window k reads samples k*H .. k*H+N-1.
  logic [DW-1:0] hist[$];
  int            deq_cnt;
  int            out_cnt;
  int            wdone;
  logic [DW-1:0] pend_rd;
  logic          stall_q;
  logic [DW-1:0] stall_data;
  logic [AW-1:0] stall_idx;
  logic          stall_last;

  // RAM model: data for a dequeue seen in cycle t is presented throughout cycle t+1.
  always @(posedge clock) begin
    #1;
    rd_data = pend_rd;
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset_n) begin
      hist.delete();
      deq_cnt = 0;
      out_cnt = 0;
      wdone   = 0;
      stall_q = 1'b0;
    end else begin
      int ahead_m;
      ahead_m = hist.size() - H * wdone;
      check("s_ready_model", s_ready, ahead_m < N);
      check("enqueue_strobe", enqueue, s_valid && (ahead_m < N));
      if (s_valid) check("wr_data", wr_data, s_data);
      if (stall_q) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, stall_data);
        check("stall_index", m_index, stall_idx);
        check("stall_last", m_last, stall_last);
      end
      if (m_valid && m_ready) begin
        int src;
        src = (out_cnt / N) * H + (out_cnt % N);
        if (src < hist.size()) check("out_data", m_data, hist[src]);
        else check("out_beyond_input", src, hist.size());
        check("out_index", m_index, out_cnt % N);
        check("out_last", m_last, (out_cnt % N) == N - 1);
        out_cnt++;
      end
      if (dequeue) begin
        int src;
        src = (deq_cnt / N) * H + (deq_cnt % N);
        check("deq_busy", busy, 1);
        check("deq_underflow", src < hist.size(), 1);
        pend_rd = (src < hist.size()) ? hist[src] : 16'hdead;
        if ((deq_cnt % N) == N - 1) wdone++;
        deq_cnt++;
        check("deq_outstanding", (deq_cnt - out_cnt) <= 2, 1);
      end
      if (enqueue) hist.push_back(s_data);
      stall_q    = m_valid && !m_ready;
      stall_data = m_data;
      stall_idx  = m_index;
      stall_last = m_last;
    end
  end

  // Feed n samples; seq_base >= 0 gives data seq_base+1.. with valid held; rp < 0 gives the
  // m_ready pattern 1,0,0,1.
  task automatic feed(input int n, input int vp, input int rp, input int seq_base);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 2000) begin
      @(posedge clock);
      #1;
      if (seq_base >= 0) begin
        s_valid = 1'b1;
        s_data  = DW'(seq_base + acc + 1);
      end else begin
        s_valid = ($urandom_range(99) < vp);
        s_data  = DW'($urandom);
      end
      if (rp < 0) m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else m_ready = ($urandom_range(99) < rp);
      @(negedge clock);
      if (s_valid && s_ready) acc++;
      cyc++;
    end
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    if (acc < n) check("feed_timeout", acc, n);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      s_valid = 1'b0;
      m_ready = rdy;
    end
  endtask

  task automatic wait_out(input int target);
    int cyc = 0;
    m_ready = 1'b1;
    while (out_cnt < target && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("wait_out_count", out_cnt, target);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    s_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    int feed;
    int vp;
    int rp;
    int exp_win;
  } row_t;

  row_t rows[6];

  initial begin
    rows[0] = '{feed: 8,  vp: 100, rp: 100, exp_win: 1};
    rows[1] = '{feed: 12, vp: 50,  rp: 70,  exp_win: 2};
    rows[2] = '{feed: 20, vp: 80,  rp: 30,  exp_win: 4};
    rows[3] = '{feed: 7,  vp: 100, rp: 100, exp_win: 0};
    rows[4] = '{feed: 30, vp: 60,  rp: 60,  exp_win: 6};
    rows[5] = '{feed: 15, vp: 90,  rp: 50,  exp_win: 2};

    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    rd_data = '0;
    pend_rd = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset values.
    @(negedge clock);
    check("rst_s_ready", s_ready, 1);
    check("rst_enqueue", enqueue, 0);
    check("rst_dequeue", dequeue, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_index", m_index, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);

    // First window from samples 1..8.
    feed(8, 100, 100, 0);
    @(negedge clock);
    check("stall_after_8", s_ready, 0);
    wait_out(8);
    check("s_ready_back", s_ready, 1);

    // Second window: samples 9..12 complete 5..12.
    feed(4, 100, 100, 8);
    wait_out(16);

    // Valid held high across a window end.
    feed(6, 100, 100, 12);
    idle(30, 1'b1);
    check("held_windows", out_cnt, 24);

    // m_ready pattern 1,0,0,1 over several windows.
    do_reset();
    feed(24, 100, -1, -1);
    idle(40, 1'b1);
    check("pattern_outputs", out_cnt, 5 * N);

    // Randomized rows with hand-computed window counts.
    foreach (rows[r]) begin
      do_reset();
      feed(rows[r].feed, rows[r].vp, rows[r].rp, -1);
      idle(40, 1'b1);
      check($sformatf("row%0d_outputs", r), out_cnt, rows[r].exp_win * N);
      check($sformatf("row%0d_dequeues", r), deq_cnt, rows[r].exp_win * N);
    end

    // Reset mid-burst at m_index 3.
    do_reset();
    feed(8, 100, 100, -1);
    begin
      int cyc = 0;
      m_ready = 1'b1;
      @(negedge clock);
      while (!(m_valid && m_index == 3) && cyc < 40) begin
        @(negedge clock);
        cyc++;
      end
      check("reached_index3", m_index, 3);
    end
    do_reset();
    @(negedge clock);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_ready", s_ready, 1);
    check("mid_rst_dequeue", dequeue, 0);
    feed(8, 100, 100, -1);
    idle(30, 1'b1);
    check("post_rst_outputs", out_cnt, N);

    // Downstream stalled for a whole burst.
    do_reset();
    feed(8, 100, 0, -1);
    idle(20, 1'b0);
    @(negedge clock);
    check("stalled_dequeues", deq_cnt, 2);
    check("stalled_valid", m_valid, 1);
    idle(30, 1'b1);
    check("release_outputs", out_cnt, N);
    check("release_dequeues", deq_cnt, N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
